stream_rr_arb: RTL and testbench
================================

# stream_rr_arb

Round-robin arbiter that merges N producer streams into one consumer stream in the array datapath. Each stream uses the valid/ready/data handshake, with an added `last` flag. One input beat is accepted per cycle into a registered output slot. An optional packet lock holds the grant on one requester from its first beat to its `last` beat. The block sits between the per-lane producers and a shared consumer, for example a result writeback or a shared memory port.

## Interface
- `N`, default 4: number of requesters; N ≥ 2.
- `W`, default 32: data width per stream.
- `IW`, derived as $clog2(N): width of the source index.

- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, N: per-requester valid.
- `in_ready`, output, N: per-requester ready; at most one bit is high in any cycle.
- `in_data`, input, N*W: requester i occupies bits [i*W +: W].
- `in_last`, input, N: per-requester end-of-packet flag.
- `out_valid`, output, 1: output slot holds a beat.
- `out_ready`, input, 1: the consumer accepts the beat.
- `out_data`, output, W: registered beat data.
- `out_last`, output, 1: registered last flag.
- `out_src`, output, IW: index of the requester that produced the current output beat.

## Operation
- **Slot free:** `free = !out_valid || out_ready`.
- **Grant selection:**
  - The grant is combinational each cycle.
  - Scan indices ptr+1, ptr+2, … modulo N and pick the first i with `in_valid[i]`.
  - If no requester is valid, there is no grant.
- **Ready:** `in_ready[i] = free && grant_valid && (grant == i)`. `in_ready` may depend on `in_valid`. Producers must not make `in_valid` depend on `in_ready`.
- **Accept:** an accept occurs when `in_valid[g] && in_ready[g]`. On accept:
  - `out_data`, `out_last` and `out_src` load the granted beat.
  - `out_valid` becomes 1.
  - `ptr` becomes g.
- **No accept:** if `out_ready` is high and no beat is accepted, `out_valid` becomes 0.
- **Output hold:** while `out_valid && !out_ready`, `out_data`, `out_last` and `out_src` hold their values.
- **Pointer:** `ptr` is IW bits and wraps from N-1 to 0. It changes only on accept.
- **State:** `IDLE` when `out_valid` is 0, `HOLD` when `out_valid` is 1. With lock enabled there is an additional `locked`/`lock_idx` register pair (see Configuration).
- **Reset values:**
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_src` = 0.
  - `ptr` = N-1, so index 0 has first priority.
  - `locked` = 0, `lock_idx` = 0.
  - `in_ready` = 0 while `rst` is high.
- **Reset mid-packet:** the beat in the output slot is dropped and the lock is cleared. No partial state survives.

## Timing
- Latency is 1 cycle: a beat accepted in cycle t appears on `out_*` in cycle t+1.
- Throughput is 1 beat per cycle when `out_ready` is held high. A new accept in the same cycle that the consumer takes the old beat gives back-to-back beats with no bubble.
- With `out_ready` low and `out_valid` high, all `in_ready` are 0. No beat is lost or duplicated.
- Fairness: with all N requesters continuously valid, grants follow the order 0, 1, …, N-1, 0, … (per beat, or per packet when lock is enabled).
- When a single requester is valid alone, it is granted every free cycle regardless of `ptr`.

## Configuration
- **Macro:** `STREAM_ARB_LOCK_EN`.
- **Defined:**
  - An accept with `in_last` = 0 sets `locked` = 1 and `lock_idx` = g.
  - While locked, the grant is forced to `lock_idx`. Other requesters see `in_ready` = 0 even when the locked requester is invalid (idle gap).
  - An accept from `lock_idx` with `in_last` = 1 clears `locked`.
  - `ptr` updates normally, so the next packet goes to the next requester after `lock_idx`.
  - A single-beat packet (`last` = 1 on the first beat) never sets the lock.
- **Undefined:**
  - The `locked`/`lock_idx` registers are absent.
  - Arbitration happens every beat and `in_last` is passed through unmodified.
  - Packets from different requesters may interleave at beat granularity.

## Test plan
- **Reset:** hold `rst` for 3 cycles with all `in_valid` = 1 → all `in_ready` = 0, `out_valid` = 0, `out_data` = 0. In the first cycle after reset, `in_ready` = 4'b0001.
- **Round-robin, N=4:** all valid, `out_ready` = 1, `in_data[i]` = 32'hA0+i → `out_src` sequence 0,1,2,3,0 on consecutive cycles, each beat one cycle after its accept.
- **Backpressure:** `out_ready` = 0 for 5 cycles while `out_valid` = 1 with data 32'hA1 → `out_data` stays 32'hA1 and all `in_ready` = 0. When `out_ready` rises, the next beat follows with no gap.
- **Sparse request:** only `in_valid[2]` high for 4 cycles → 4 beats, all with `out_src` = 2. Then `in_valid[1]` and `in_valid[3]` both high → `out_src` = 3, then 1.
- **Lock (`STREAM_ARB_LOCK_EN`):**
  - Requester 1 sends a 3-beat packet, `last` on beat 3, while requester 2 is valid throughout → `out_src` = 1,1,1, then 2.
  - Insert a 2-cycle `in_valid[1]` gap mid-packet → requester 2 stays blocked through the gap.
- **Reset mid-packet (lock enabled):** assert `rst` after beat 1 of a 3-beat packet from requester 1 → lock cleared. After reset, requester 0 (valid) is granted first.

Source files
------------

// File: rtl/stream_rr_arb_if.sv
// Valid/ready/data/last bundle between N producers, the arbiter and one consumer.
interface stream_rr_arb_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [IW-1:0]  out_src;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_src
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_src
    );
endinterface

// File: rtl/stream_rr_arb.sv
// Round-robin N:1 stream merge into a registered output slot.
// Optional packet lock (grant held from first to last beat): define STREAM_ARB_LOCK_EN.
module stream_rr_arb #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
) (
    input  logic            clk,
    input  logic            rst,
    stream_rr_arb_if.slave  bus
);
    localparam int unsigned IW = $clog2(N);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_data, w_data_nxt;
    logic          r_last, w_last_nxt;
    logic [IW-1:0] r_src, w_src_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
`ifdef STREAM_ARB_LOCK_EN
    logic          r_locked, w_locked_nxt;
    logic [IW-1:0] r_lock_idx, w_lock_idx_nxt;
`endif

    logic          w_free;
    logic          w_gnt_valid;
    logic          w_accept;
    logic [IW-1:0] w_gnt;
    logic [IW-1:0] w_idx;
    logic [W-1:0]  w_gnt_data;
    logic          w_gnt_last;

    // Scan ptr+1 .. ptr+N; descending loop so the nearest valid index wins.
    always_comb begin
        w_gnt       = '0;
        w_gnt_valid = 1'b0;
        w_idx       = '0;
        for (int k = int'(N); k >= 1; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % int'(N));
            if (bus.in_valid[w_idx]) begin
                w_gnt       = w_idx;
                w_gnt_valid = 1'b1;
            end
        end
`ifdef STREAM_ARB_LOCK_EN
        if (r_locked) begin
            w_gnt       = r_lock_idx;
            w_gnt_valid = bus.in_valid[r_lock_idx];
        end
`endif
    end

    always_comb begin
        w_gnt_data = '0;
        w_gnt_last = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_gnt == IW'(i)) begin
                w_gnt_data = bus.in_data[i*int'(W) +: W];
                w_gnt_last = bus.in_last[i];
            end
        end
    end

    assign w_free       = (r_state == IDLE) || bus.out_ready;
    assign w_accept     = w_free && w_gnt_valid && !rst;
    assign bus.in_ready = w_accept ? (N'(1) << w_gnt) : '0;

    // Next-state and slot load.
    always_comb begin
        w_state_nxt    = r_state;
        w_data_nxt     = r_data;
        w_last_nxt     = r_last;
        w_src_nxt      = r_src;
        w_ptr_nxt      = r_ptr;
`ifdef STREAM_ARB_LOCK_EN
        w_locked_nxt   = r_locked;
        w_lock_idx_nxt = r_lock_idx;
`endif
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = HOLD;
            HOLD: if (!w_accept && bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_accept) begin
            w_data_nxt = w_gnt_data;
            w_last_nxt = w_gnt_last;
            w_src_nxt  = w_gnt;
            w_ptr_nxt  = w_gnt;
`ifdef STREAM_ARB_LOCK_EN
            if (!w_gnt_last) begin
                w_locked_nxt   = 1'b1;
                w_lock_idx_nxt = w_gnt;
            end else begin
                w_locked_nxt   = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_src      <= '0;
            r_ptr      <= IW'(N - 1);
`ifdef STREAM_ARB_LOCK_EN
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_last     <= w_last_nxt;
            r_src      <= w_src_nxt;
            r_ptr      <= w_ptr_nxt;
`ifdef STREAM_ARB_LOCK_EN
            r_locked   <= w_locked_nxt;
            r_lock_idx <= w_lock_idx_nxt;
`endif
        end
    end

    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_data  = r_data;
    assign bus.out_last  = r_last;
    assign bus.out_src   = r_src;
endmodule

// File: tb/tb_stream_rr_arb.sv
// Bench for stream_rr_arb: directed scenarios plus randomized producers against a beat-level model.
module tb_stream_rr_arb;
    localparam int N = 4;
    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic [W-1:0] d [N];
    logic         ordy;

    int checks;
    int failures;

    // Model state: pointer, output slot, packet lock.
    int           m_ptr;
    bit           m_valid;
    logic [W-1:0] m_data;
    bit           m_last;
    int           m_src;
    bit           m_locked;
    int           m_lock_idx;
    logic [N-1:0] acc;

    stream_rr_arb_if #(.N(N), .W(W)) bus ();

    stream_rr_arb #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.in_valid  = v;
    assign bus.in_last   = l;
    assign bus.in_data   = {d[3], d[2], d[1], d[0]};
    assign bus.out_ready = ordy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr      = N - 1;
        m_valid    = 0;
        m_data     = '0;
        m_last     = 0;
        m_src      = 0;
        m_locked   = 0;
        m_lock_idx = 0;
    endtask

    // First valid index after ptr in circular order, or the locked owner.
    task automatic model_grant(output int g, output bit gv);
        g  = 0;
        gv = 0;
        if (m_locked) begin
            g  = m_lock_idx;
            gv = v[g];
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!gv && v[i]) begin
                    g  = i;
                    gv = 1;
                end
            end
        end
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge.
    task automatic step();
        int           g;
        bit           gv;
        bit           free;
        logic [N-1:0] er;
        #1;
        model_grant(g, gv);
        free = !m_valid || ordy;
        er   = (rst || !(free && gv)) ? '0 : N'(1 << g);
        chk("in_ready", 64'(bus.in_ready), 64'(er));
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("out_data", 64'(bus.out_data), 64'(m_data));
            chk("out_last", 64'(bus.out_last), 64'(m_last));
            chk("out_src", 64'(bus.out_src), 64'(m_src));
        end
        acc = er & v;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (free && gv) begin
            m_valid = 1;
            m_data  = d[g];
            m_last  = l[g];
            m_src   = g;
            m_ptr   = g;
`ifdef STREAM_ARB_LOCK_EN
            if (!l[g]) begin
                m_locked   = 1;
                m_lock_idx = g;
            end else begin
                m_locked = 0;
            end
`endif
        end else if (ordy) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        acc  = '0;
        rst  = 1'b1;
        v    = '1;
        l    = '1;
        ordy = 1'b1;
        for (int i = 0; i < N; i++) d[i] = 32'hA0 + 32'(i);

        // Reset held with every requester valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_out_data", 64'(bus.out_data), 64'h0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.in_ready), 64'b0001);

        // Round-robin with all valid.
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_src", 64'(bus.out_src), 64'(k % N));
            chk("rr_data", 64'(bus.out_data), 64'h0A0 + 64'(k % N));
        end

        // Backpressure while holding requester 1's beat.
        step();
        chk("bp_first", 64'(bus.out_data), 64'hA1);
        ordy = 1'b0;
        repeat (5) begin
            #1;
            chk("bp_ready", 64'(bus.in_ready), 64'h0);
            chk("bp_data", 64'(bus.out_data), 64'hA1);
            step();
        end
        ordy = 1'b1;
        step();
        chk("bp_resume_valid", 64'(bus.out_valid), 64'h1);
        chk("bp_resume_src", 64'(bus.out_src), 64'h2);

        // Sparse request: only 2, then 1 and 3 together.
        v = 4'b0100;
        repeat (4) begin
            step();
            chk("sparse_src2", 64'(bus.out_src), 64'h2);
        end
        v = 4'b1010;
        step();
        chk("sparse_src3", 64'(bus.out_src), 64'h3);
        step();
        chk("sparse_src1", 64'(bus.out_src), 64'h1);

`ifdef STREAM_ARB_LOCK_EN
        // Packet from requester 1 with a mid-packet gap; requester 2 must wait.
        v = 4'b0001;
        step();
        v = 4'b0110;
        l = 4'b0100;
        step();
        chk("lock_b1", 64'(bus.out_src), 64'h1);
        step();
        chk("lock_b2", 64'(bus.out_src), 64'h1);
        v = 4'b0100;
        repeat (2) begin
            #1;
            chk("lock_gap_ready", 64'(bus.in_ready), 64'h0);
            step();
        end
        chk("lock_gap_idle", 64'(bus.out_valid), 64'h0);
        v = 4'b0110;
        l = 4'b0110;
        step();
        chk("lock_b3_src", 64'(bus.out_src), 64'h1);
        chk("lock_b3_last", 64'(bus.out_last), 64'h1);
        step();
        chk("lock_next_src", 64'(bus.out_src), 64'h2);

        // Reset after the first beat of a packet clears the lock.
        v = 4'b0010;
        l = 4'b0000;
        step();
        chk("rstlock_b1", 64'(bus.out_src), 64'h1);
        rst = 1'b1;
        v   = 4'b0011;
        step();
        rst = 1'b0;
        #1;
        chk("rstlock_ready", 64'(bus.in_ready), 64'b0001);
        step();
        chk("rstlock_src", 64'(bus.out_src), 64'h0);
`endif

        // Randomized producers that hold each beat until it is taken.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !v[i]) begin
                    v[i] = ($urandom_range(0, 3) != 0);
                    d[i] = $urandom;
                    l[i] = ($urandom_range(0, 2) == 0);
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
